// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Wide enough to slice down to any supported operand width.
  localparam logic [63:0] ALL_ONES_PATTERN = '1;

  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// div_by_zero exists only when DIV_ZERO_FAST_EN is defined.
interface seq_restoring_divider_if #(parameter int N = 8);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV_ZERO_FAST_EN
  logic         div_by_zero;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder);
`endif

endinterface

// File: rtl/seq_restoring_divider_borrow_subtractor.sv
// Purely combinational ripple-borrow subtractor: diff_o = a_i - b_i - borrow_i.
module borrow_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         borrow_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  always_comb begin
    logic br;
    br     = borrow_i;
    diff_o = '0;
    for (int i = 0; i < W; i++) begin
      diff_o[i] = a_i[i] ^ b_i[i] ^ br;
      br        = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br);
    end
    borrow_o = br;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned N-bit restoring divider, one subtractor reused once per cycle.
// Define DIV_ZERO_FAST_EN to short-circuit divide-by-zero and expose div_by_zero.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int             CW           = cntWidth(N);
  localparam logic [N-1:0]   QUO_ALL_ONES = ALL_ONES_PATTERN[N-1:0];

  divState_e     state_q, state_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic [N:0]    part_q, part_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    tVal, diffVal;
  logic          borrowOut;
`ifdef DIV_ZERO_FAST_EN
  logic          dbz_q, dbz_d;
`endif

  // The partial remainder's top bit falls off the shift; quo_q's MSB enters at the bottom.
  assign tVal = (part_q << 1) | {{N{1'b0}}, quo_q[N-1]};

  borrow_subtractor #(.W(N + 1)) u_sub (
    .a_i      (tVal),
    .b_i      ({1'b0, divisor_q}),
    .borrow_i (1'b0),
    .diff_o   (diffVal),
    .borrow_o (borrowOut)
  );

  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    quo_d       = quo_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_FAST_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          divisor_d = bus.divisor;
          quo_d     = bus.dividend;
          part_d    = '0;
          cnt_d     = '0;
          state_d   = CALC;
`ifdef DIV_ZERO_FAST_EN
          if (bus.divisor == '0) begin
            quotient_d  = QUO_ALL_ONES;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      CALC: begin
        part_d = borrowOut ? tVal : diffVal;
        quo_d  = {quo_q[N-2:0], ~borrowOut};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quotient_d  = {quo_q[N-2:0], ~borrowOut};
          remainder_d = part_d[N-1:0];
`ifdef DIV_ZERO_FAST_EN
          dbz_d       = 1'b0;
`endif
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      quo_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_FAST_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      quo_q       <= quo_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_FAST_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIV_ZERO_FAST_EN
  assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised self-checking bench for seq_restoring_divider against a plain-arithmetic model.
// Honours DIV_ZERO_FAST_EN the same way the design does.
module tb_seq_restoring_divider;

  localparam int N       = 8;
  localparam int TIMEOUT = 4 * N;

  logic clk = 1'b0;
  logic rst_n;
  int   vectorCount     = 0;
  int   miscompareCount = 0;

  seq_restoring_divider_if #(.N(N)) divIf ();

  seq_restoring_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (divIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Division as the issuing controller sees it, including the divide-by-zero convention.
  function automatic void refDivide(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] expQ, expR;
    int           expLat;
    int           lat;
    refDivide(a, b, expQ, expR);
    expLat = N;
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) expLat = 0;
`endif
    @(negedge clk);
    divIf.start    = 1'b1;
    divIf.dividend = a;
    divIf.divisor  = b;
    @(negedge clk);
    divIf.start    = 1'b0;
    divIf.dividend = N'($urandom);
    divIf.divisor  = N'($urandom);
    checkOutput("busyAfterAccept", 32'(divIf.busy), 32'(1));
    lat = 0;
    while (divIf.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("busyAtDone", 32'(divIf.busy), 32'(1));
    checkOutput("quotient", 32'(divIf.quotient), 32'(expQ));
    checkOutput("remainder", 32'(divIf.remainder), 32'(expR));
`ifdef DIV_ZERO_FAST_EN
    checkOutput("divByZero", 32'(divIf.div_by_zero), 32'(b == '0));
`endif
    @(negedge clk);
    checkOutput("donePulse", 32'(divIf.done), 32'(0));
    checkOutput("busyCleared", 32'(divIf.busy), 32'(0));
  endtask

  initial begin
    int lat;
    rst_n          = 1'b0;
    divIf.start    = 1'b0;
    divIf.dividend = '0;
    divIf.divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 32'(divIf.busy), 32'(0));
    checkOutput("resetDone", 32'(divIf.done), 32'(0));
    checkOutput("resetQuotient", 32'(divIf.quotient), 32'(0));
    checkOutput("resetRemainder", 32'(divIf.remainder), 32'(0));
`ifdef DIV_ZERO_FAST_EN
    checkOutput("resetDivByZero", 32'(divIf.div_by_zero), 32'(0));
`endif
    rst_n = 1'b1;

    applyStimulus(8'd100, 8'd7);
    applyStimulus(8'd255, 8'd1);
    applyStimulus(8'd5, 8'd9);
    applyStimulus(8'd0, 8'd3);
    applyStimulus(8'h5A, 8'd0);
    applyStimulus(8'd255, 8'd255);

    // Start held high: the second request must wait for the idle cycle after done.
    @(negedge clk);
    divIf.start    = 1'b1;
    divIf.dividend = 8'd100;
    divIf.divisor  = 8'd7;
    @(negedge clk);
    divIf.dividend = 8'd200;
    divIf.divisor  = 8'd3;
    lat = 0;
    while (divIf.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("heldLatency1", 32'(lat), 32'(N));
    checkOutput("heldQuotient1", 32'(divIf.quotient), 32'(14));
    checkOutput("heldRemainder1", 32'(divIf.remainder), 32'(2));
    @(negedge clk);
    checkOutput("heldIdleGap", 32'(divIf.busy), 32'(0));
    lat = 1;
    while (divIf.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("heldLatency2", 32'(lat), 32'(N + 2));
    checkOutput("heldQuotient2", 32'(divIf.quotient), 32'(66));
    checkOutput("heldRemainder2", 32'(divIf.remainder), 32'(2));
    divIf.start = 1'b0;
    @(negedge clk);
    checkOutput("heldDoneClear", 32'(divIf.done), 32'(0));

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    divIf.start    = 1'b1;
    divIf.dividend = 8'd100;
    divIf.divisor  = 8'd7;
    @(negedge clk);
    divIf.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(divIf.busy), 32'(0));
    checkOutput("abortDone", 32'(divIf.done), 32'(0));
    checkOutput("abortQuotient", 32'(divIf.quotient), 32'(0));
    checkOutput("abortRemainder", 32'(divIf.remainder), 32'(0));
    repeat (N + 2) @(negedge clk);
    checkOutput("abortNoDone", 32'(divIf.done), 32'(0));
    rst_n = 1'b1;
    applyStimulus(8'd50, 8'd5);

    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] a, b, tmp;
      a = N'($urandom);
      b = N'($urandom);
      case ($urandom_range(0, 4))
        1: if (a > b) begin tmp = a; a = b; b = tmp; end
        2: a = '1;
        3: b = '1;
        4: b = N'($urandom_range(0, 3));
        default: ;
      endcase
      applyStimulus(a, b);
      if (b != '0) begin
        checkOutput("identity",
                    32'(divIf.quotient) * 32'(b) + 32'(divIf.remainder), 32'(a));
        checkOutput("remLtDiv", 32'(divIf.remainder < b), 32'(1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned N-bit divider: one (N+1)-bit ripple-borrow subtractor, reused once per cycle under a small FSM.
- Produces quotient and remainder N cycles after a start pulse is accepted.
- Serves as the shared-arithmetic divide unit next to the team's combinational add/subtract datapaths.
- Start/busy/done handshake toward the issuing controller.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  N  numerator, captured on accepted start.
- divisor  input  N  denominator, captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  N  registered result, held until the next done.
- remainder  output  N  registered result, held until the next done.
- div_by_zero  output  1  present only with DIV_ZERO_FAST_EN; valid with done.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; busy, done, quotient, remainder, div_by_zero, counter and internal registers all 0. Reset asserted mid-operation aborts immediately with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge k captures the operands, clears the partial remainder P (N+1 bits) and the counter, and moves to CALC.
  - start=0 stays in IDLE.
- CALC, one iteration per edge:
  - T = {P[N-1:0], Q[N-1]}; Q <<= 1.
  - D = T - {1'b0, divisor} via the subtractor, borrow-in 0.
  - If borrow-out = 0: P = D, Q[0] = 1. Otherwise P = T, Q[0] = 0.
  - Counter increments. On the Nth iteration (edge k+N), load quotient=Q and remainder=P[N-1:0], then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle (the cycle after edge k+N), then IDLE.
- Latency: done is visible N cycles after the accepting edge. Re-issue is possible at the earliest on the cycle after done, i.e. one request per N+2 cycles.
- start while busy=1 (including the DONE cycle) is ignored, with no side effects. Operand changes after acceptance have no effect.
- All arithmetic is unsigned. Remainder is always < divisor when divisor != 0. The counter is ceil(log2(N+1)) bits and does not wrap within an operation.
- Divisor 0 without the fast path: the normal N-iteration run yields quotient = all-ones and remainder = dividend.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - The div_by_zero port exists.
  - An accepted start with divisor=0 goes IDLE -> DONE directly: done appears 1 cycle after the accepting edge, with quotient = all-ones, remainder = dividend, div_by_zero=1.
  - Otherwise div_by_zero=0 with every done. It resets to 0 and holds with the results.
- Undefined:
  - No port.
  - Divisor 0 takes the full N-cycle path, with the same quotient/remainder values.

Decomposition:
- Package div_pkg:
  - state enum typedef (IDLE, CALC, DONE);
  - function for counter width from N;
  - localparam for the all-ones quotient pattern.
- Sub-module borrow_subtractor:
  - parameterised width W (instantiated with W = N+1);
  - ports a, b, borrow-in, difference, borrow-out;
  - purely combinational ripple-borrow chain.
- The FSM, shift registers and counter live in the top module.

Test Plan:
1. N=8, dividend=100, divisor=7, start 1 cycle -> done exactly 8 cycles after the accepting edge; quotient=14, remainder=2; busy low the following cycle.
2. dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=5, divisor=9 -> quotient=0, remainder=5. dividend=0, divisor=3 -> quotient=0, remainder=0.
3. Divisor 0 with dividend=0x5A:
   - Macro defined: done 1 cycle after acceptance; quotient=0xFF, remainder=0x5A, div_by_zero=1.
   - Macro undefined: done after 8 cycles, same values.
4. Hold start high for the whole operation, with new operands 200/3 presented during busy:
   - First result 100/7 = (14, 2) is unaffected.
   - 200/3 is accepted on the cycle after done and gives (66, 2) after 8 more cycles.
5. Assert rst_n=0 at iteration 4 -> all outputs 0 asynchronously, no done. After release, a new 50/5 yields (10, 0).
6. Randomised sweep of 1000 operand pairs, including divisor > dividend and max values -> quotient*divisor + remainder == dividend and remainder < divisor whenever divisor != 0.
